seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial pattern detector: a generalised Moore-style detector for 1-bit serial streams. It compares each valid input bit against a runtime-loadable PAT_W-bit pattern and raises a registered, one-cycle `detected` pulse per match, with selectable overlapping or non-overlapping matching and a saturating match counter. It sits on the serial receive path after bit recovery and feeds framing/sync logic.

## Interface
- `PAT_W`, 4, pattern length in bits (≥ 2)
- `PAT_RESET`, 4'b1101, pattern value after reset (width PAT_W, MSB = earliest bit in time)
- `CNT_W`, 8, match counter width (≥ 1)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `in_valid`  in  1  `in_bit` qualifier; state advances only when high
- `in_bit`  in  1  serial data bit
- `overlap_en`  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- `load_pat`  in  1  synchronous pulse: capture `pattern`, flush history
- `pattern`  in  PAT_W  new pattern, MSB first in time
- `clear`  in  1  synchronous flush of history, detector output and counter
- `detected`  out  1  registered match pulse
- `match_count`  out  CNT_W  saturating count of matches
- `count_sat`  out  1  high while `match_count` is all-ones

## Operation
- State: `pat_q` (PAT_W), `hist` (PAT_W, newest bit at LSB), `fill` (0..PAT_W valid bits in `hist`), `detected`, `match_count`.
- Reset (`rst_n` low, async): `pat_q`=PAT_RESET, `hist`=0, `fill`=0, `detected`=0, `match_count`=0, `count_sat`=0.
- Valid cycle (`in_valid`=1, no clear/load): `nh`={hist[PAT_W-2:0], in_bit}; `nf`=min(fill+1, PAT_W); `hit`=(nf==PAT_W)&&(nh==pat_q).
  - `hist`<=`nh`; `detected`<=`hit`.
  - `hit` & `overlap_en`=1: `fill`<=PAT_W (history reused).
  - `hit` & `overlap_en`=0: `fill`<=0 (next match needs PAT_W fresh bits).
  - no hit: `fill`<=`nf`.
- Idle cycle (`in_valid`=0): `hist`/`fill` hold, `detected`<=0.
- `hit` increments `match_count` by 1; at all-ones it holds (no wrap).
- `load_pat`: `pat_q`<=`pattern`, `hist`<=0, `fill`<=0, `detected`<=0; counter untouched; `in_bit` that cycle discarded.
- `clear`: `hist`<=0, `fill`<=0, `detected`<=0, `match_count`<=0; `in_bit` that cycle discarded.
- Priority: `clear` and `load_pat` both take effect together and override `in_valid`.
- `overlap_en` may change any cycle; it governs only the `fill` update of the current cycle.
- No partial matches before `fill` reaches PAT_W: all-zero pattern does not fire on post-reset zeros until PAT_W valid zeros have arrived.

## Timing
- Latency: `detected` high in the cycle after the edge that samples the completing bit (one-clock registered, Moore output—no combinational path from inputs).
- `detected` width: one cycle per match; back-to-back highs only in overlap mode with self-overlapping patterns (e.g. 1111).
- `match_count` updates on the same edge as `detected` rises; `count_sat` is combinational from the `match_count` register.
- `rst_n` assertion mid-stream clears immediately; release must be synchronous to `clk` externally; first valid bit accepted on first edge after release.

## Configuration
- `SEQDET_COUNT_EN`: defined → `match_count` and `count_sat` implemented as above. Undefined → counter logic removed, `match_count` tied to 0, `count_sat` tied to 0; ports remain; `clear` still flushes history/detected.

## Test plan
- Reset, PAT_RESET=1101, overlap_en=1, stream 1101101101 (valid every cycle) -> `detected` pulses after bits 4, 7, 10; `match_count`=3.
- Same stream, overlap_en=0 -> pulses after bits 4 and 10 only; `match_count`=2.
- Stream 1,1,0,(in_valid=0 for 3 cycles),1 -> gap holds history; single pulse after final bit; `detected` low during gap.
- `load_pat` with pattern=0110 mid-stream, then 0110 -> no pulse from pre-load bits; pulse after 4th post-load bit; counter retains prior value.
- CNT_W=2, overlap_en=1, PAT_W=4, pattern=1111, stream of 8 ones -> pulses after bits 4..8 (5 consecutive cycles), `match_count` sticks at 3, `count_sat`=1; `clear` -> count 0, `count_sat`=0.
- `rst_n` low asynchronously between clock edges after 1,1,0 -> all outputs 0 immediately; subsequent single 1 gives no pulse; `pat_q` back to 1101.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlap control and
// registered match pulse. Define SEQDET_COUNT_EN to build the saturating match counter.
module seq_detector_param #(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = 4'b1101,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap_en,
    input  logic             load_pat,
    input  logic [PAT_W-1:0] pattern,
    input  logic             clear,
    output logic             detected,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // Stream qualifier: in_bit is consumed on a rising edge only when in_valid
    // is high and neither clear nor load_pat is asserted; there is no backpressure.
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] nf;
    logic              hit;
    logic              flush;

    always_comb begin
        nh  = {hist[PAT_W-2:0], in_bit};
        nf  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit = (nf == FILL_FULL) && (nh == pat_q);
    end

    assign flush = clear | load_pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q    <= PAT_RESET;
            hist     <= '0;
            fill     <= '0;
            detected <= 1'b0;
        end else if (flush) begin
            hist     <= '0;
            fill     <= '0;
            detected <= 1'b0;
            if (load_pat) begin
                pat_q <= pattern;
            end
        end else if (in_valid) begin
            hist     <= nh;
            detected <= hit;
            // Non-overlapping mode discards the matched bits so the next match starts fresh.
            if (hit) begin
                fill <= overlap_en ? FILL_FULL : '0;
            end else begin
                fill <= nf;
            end
        end else begin
            detected <= 1'b0;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (!load_pat && in_valid && hit && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
    assign count_sat   = &cnt_q;
`else
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule
